// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending-write scoreboard and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN for a same-cycle write-to-read bypass; the default build reads stored state only.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREAD*ADDR_W-1:0] i_raddr,
  output logic [NREAD*DATA_W-1:0] o_rdata,
  output logic [NREAD-1:0]        o_rbusy,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_claim,
  input  logic [ADDR_W-1:0]       i_claim_addr,
  output logic                    o_ready
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]    sb_q, sb_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                run, wr_en, claim_en, byp;
  logic [ADDR_W-1:0]   ra;

  always_comb begin
    run      = (state_q == ST_RUN);
    wr_en    = run && i_we && !(ZERO_REG != 0 && i_waddr == '0);
    claim_en = run && i_claim && !(ZERO_REG != 0 && i_claim_addr == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sb_q    <= sb_d;
    end
  end

  // Claim is applied after the write clear so a same-address claim wins.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sb_d    = sb_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_en)    sb_d[i_waddr]      = 1'b0;
        if (claim_en) sb_d[i_claim_addr] = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Array has no reset; the sweep zeroes one entry per cycle instead.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == ST_CLEAR) mem_q[ptr_q] <= '0;
      else if (wr_en)          mem_q[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_ready = run;
    o_rdata = '0;
    o_rbusy = '0;
    ra      = '0;
    byp     = 1'b0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = i_raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      byp = i_we && (i_waddr == ra);
`else
      byp = 1'b0;
`endif
      if (run && !(ZERO_REG != 0 && ra == '0)) begin
        if (byp) begin
          o_rdata[k*DATA_W +: DATA_W] = i_wdata;
          o_rbusy[k]                  = claim_en && (i_claim_addr == ra);
        end else begin
          o_rdata[k*DATA_W +: DATA_W] = mem_q[ra];
          o_rbusy[k]                  = sb_q[ra];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS core and its successors. It provides NREAD combinational read ports, one synchronous write port and an optional hardwired zero register. A per-register pending-write scoreboard supports pipeline hazard detection. After reset, a sequential clear sweep zeroes the array one entry per cycle, so no wide single-cycle reset of the array is needed.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports (1..8)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and claims
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_raddr  in  NREAD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- o_rdata  out  NREAD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- o_rbusy  out  NREAD  scoreboard bit of the register addressed by port k
- i_we  in  1  write enable
- i_waddr  in  ADDR_W  write address
- i_wdata  in  DATA_W  write data
- i_claim  in  1  mark i_claim_addr as pending a write
- i_claim_addr  in  ADDR_W  register being claimed
- o_ready  out  1  high when the clear sweep is done and the block accepts writes and claims

## Operation
- Two states, CLEAR and RUN. Reset state is CLEAR with ptr=0, all scoreboard bits 0 and o_ready=0.
- CLEAR:
  - While i_rst is high, the block stays in CLEAR with ptr held at 0.
  - Once i_rst is low, each cycle writes 0 to reg[ptr] and increments ptr.
  - After reg[DEPTH-1] is written, the next state is RUN.
  - i_we and i_claim are ignored.
  - o_rdata is all zeros and o_rbusy is all zeros.
- RUN:
  - o_ready=1.
  - Write: if i_we=1 and not (ZERO_REG=1 and i_waddr=0), then reg[i_waddr] <= i_wdata. The same edge clears scoreboard[i_waddr].
  - Claim: if i_claim=1 and not (ZERO_REG=1 and i_claim_addr=0), then scoreboard[i_claim_addr] <= 1.
  - Write and claim to the same address in the same cycle: the data is written and the scoreboard bit ends at 1 (set wins; the new producer is outstanding).
  - A write to a register with no pending claim is legal and leaves its bit at 0.
- Reads: o_rdata[k] = reg[i_raddr[k]] and o_rbusy[k] = scoreboard[i_raddr[k]]. If ZERO_REG=1 and i_raddr[k]=0, both are 0.
- Any number of ports may address the same register; each returns the same value.
- i_rst=1 in RUN: on the next edge the block enters CLEAR, ptr=0, scoreboard is cleared and o_ready=0. Contents not yet swept keep stale values but are never visible, because reads return 0 in CLEAR.

## Timing
- Read ports are purely combinational: zero-cycle latency from i_raddr to o_rdata/o_rbusy.
- A write is visible on read ports the cycle after its edge (same cycle with bypass; see Configuration).
- A claim is visible on o_rbusy the cycle after its edge.
- The clear sweep takes exactly DEPTH cycles after i_rst falls. o_ready rises on the edge that completes cycle DEPTH.
- No outputs are registered. All state changes occur only on the rising edge of i_clk.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, when i_we=1 and i_waddr==i_raddr[k] (excluding register 0 when ZERO_REG=1):
  - o_rdata[k] = i_wdata in the same cycle.
  - o_rbusy[k] = 0, unless i_claim to the same address is also active that cycle, in which case o_rbusy[k]=1.
- REGFILE_BYPASS_EN undefined: read ports see only stored state; write data appears one cycle later.

## Test plan
- Reset sweep: DATA_W=32, ADDR_W=5. Pulse i_rst for 2 cycles, release -> o_ready stays 0 for exactly 32 cycles, then rises. Reading all 32 registers returns 0x00000000. Writes during the sweep are dropped.
- Basic write/read: write 0xDEADBEEF to r5, then read r5 on ports 0 and 1 next cycle -> both 0xDEADBEEF. Writing 0x12345678 to r0 -> r0 reads 0.
- Scoreboard: claim r7 -> o_rbusy=1 on the next cycle. Write r7 with 0xA5A5A5A5 -> busy 0 and data 0xA5A5A5A5 next cycle. Claim and write r7 in the same cycle -> busy remains 1.
- Bypass (macro defined): read r9 while writing 0x0000CAFE to r9 -> o_rdata=0x0000CAFE in the same cycle. Macro undefined -> the old value in the same cycle, 0x0000CAFE next cycle.
- Mid-operation reset: claim r3 and write r4=0x55 in RUN, then assert i_rst one cycle -> o_ready=0, o_rbusy=0 and reads 0 during the sweep. After 32 cycles r4 reads 0 and r3 is not busy.
- Parametrised instance: NREAD=4, ADDR_W=3, DATA_W=16. Write r1..r4 = 0x1111..0x4444 and read all four ports simultaneously -> correct values. Sweep length is 8 cycles.
